fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 35 +++
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// Carries the clock enable, flush, the push/pop handshakes and the queue status.
interface fetch_queue_if #(
    parameter int unsigned width = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              clkEn;
    logic              flushEn;
    logic              inValid;
    logic [width-1:0]  inPC;
    logic [31:0]       inInstr;
    logic              inReady;
    logic              stallReq;
    logic              stallStart;
    logic              outValid;
    logic [width-1:0]  outPC;
    logic [31:0]       outInstr;
    logic              outReady;
    logic [CW-1:0]     count;
    logic              overflow;

    // Queue side
    modport slave (
        input  clkEn, flushEn, inValid, inPC, inInstr, outReady,
        output inReady, stallReq, stallStart, outValid, outPC, outInstr, count, overflow
    );

    // Fetch/decode side
    modport master (
        output clkEn, flushEn, inValid, inPC, inInstr, outReady,
        input  inReady, stallReq, stallStart, outValid, outPC, outInstr, count, overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of {PC, instruction} between fetch and decode.
// Optional same-cycle empty-queue bypass enabled by macro FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned width = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.slave   fq
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [width-1:0] pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          stall_prev_q, stall_prev_d;

    logic empty_c, full_c, stall_c;
    logic byp_c, push_c, pop_c;

    // Status flags depend on the occupancy register only, never on outReady
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == CW'(DEPTH));
        stall_c = (count_q >= CW'(DEPTH - 1));
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_c = empty_c && fq.inValid && !fq.flushEn;
`else
    assign byp_c = 1'b0;
`endif

    // A bypassed instruction taken by decode in the same cycle is never written
    always_comb begin
        push_c = fq.clkEn && fq.inValid && !full_c && !fq.flushEn
                 && !(byp_c && fq.outReady);
        pop_c  = fq.clkEn && !empty_c && fq.outReady && !fq.flushEn;
    end

    // Next-state logic for pointers, occupancy and sticky flags
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        stall_prev_d = stall_prev_q;

        if (fq.clkEn) begin
            stall_prev_d = stall_c;
            if (fq.inValid && full_c) begin
                overflow_d = 1'b1;
            end
            if (fq.flushEn) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_c) begin
                    tail_d = tail_q + PW'(1);
                end
                if (pop_c) begin
                    head_d = head_q + PW'(1);
                end
                case ({push_c, pop_c})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            stall_prev_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            stall_prev_q <= stall_prev_d;
        end
    end

    // Storage is not reset; the head mask below hides stale entries
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            pc_mem_q[tail_q]    <= fq.inPC;
            instr_mem_q[tail_q] <= fq.inInstr;
        end
    end

    always_comb begin
        fq.outValid = !empty_c && !fq.flushEn;
        fq.outPC    = '0;
        fq.outInstr = '0;
        if (!empty_c) begin
            fq.outPC    = pc_mem_q[head_q];
            fq.outInstr = instr_mem_q[head_q];
        end
        if (byp_c) begin
            fq.outValid = 1'b1;
            fq.outPC    = fq.inPC;
            fq.outInstr = fq.inInstr;
        end
    end

    assign fq.inReady    = !full_c;
    assign fq.stallReq   = stall_c;
    assign fq.stallStart = stall_c && !stall_prev_q;
    assign fq.count      = count_q;
    assign fq.overflow   = overflow_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue (DEPTH 4); expected values hand-computed.
module tb_fetch_queue;
    localparam int unsigned W = 32;
    localparam int unsigned D = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.width(W), .DEPTH(D)) fq ();
    fetch_queue #(.width(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .fq(fq));

    typedef struct {
        logic        rst, ce, fl, iv;
        logic [31:0] pc;
        logic        ordy, chk;
        logic        e_ov;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_ird, e_st, e_ss, e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input int r, ce, fl, iv, pc, ordy, chk,
                                input int ov, epc, cnt, ird, st, ss, ovf);
        vec_t v;
        v.rst = 1'(r);   v.ce = 1'(ce);   v.fl = 1'(fl);   v.iv = 1'(iv);
        v.pc = 32'(pc);  v.ordy = 1'(ordy); v.chk = 1'(chk);
        v.e_ov = 1'(ov); v.e_pc = 32'(epc); v.e_cnt = 3'(cnt);
        v.e_ird = 1'(ird); v.e_st = 1'(st); v.e_ss = 1'(ss); v.e_ovf = 1'(ovf);
        return v;
    endfunction

    task automatic cmp(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, ce, fl, iv, input logic [31:0] pc, input logic ordy);
        rst         = r;
        fq.clkEn    = ce;
        fq.flushEn  = fl;
        fq.inValid  = iv;
        fq.inPC     = pc;
        fq.inInstr  = instr_of(pc);
        fq.outReady = ordy;
    endtask

    initial begin
        logic        e_ov;
        logic [31:0] e_pc, e_in;

        // rst ce fl iv pc ordy chk | outValid outPC count inReady stallReq stallStart overflow
        vecs.push_back(mk(1,0,0,0,0,0,0,     0,0,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,1,     0,0,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,1,'h0,0,1,   0,0,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,1,'h4,0,1,   1,'h0,1,1,0,0,0));
        vecs.push_back(mk(0,1,0,1,'h8,0,1,   1,'h0,2,1,0,0,0));
        vecs.push_back(mk(0,1,0,1,'hC,0,1,   1,'h0,3,1,1,1,0));
        vecs.push_back(mk(0,1,0,1,'h10,0,1,  1,'h0,4,0,1,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,1,     1,'h0,4,0,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,1,1,     1,'h0,4,0,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,1,1,     1,'h4,3,1,1,0,1));
        // push+pop at count 2, tail and head wrap
        vecs.push_back(mk(0,1,0,1,'h20,1,1,  1,'h8,2,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h24,1,1,  1,'hC,2,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h28,1,1,  1,'h20,2,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,1,1,     1,'h24,2,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,1,1,     1,'h28,1,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,1,     0,0,0,1,0,0,1));
        // refill, then push while full with concurrent pop
        vecs.push_back(mk(0,1,0,1,'h30,0,1,  0,0,0,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h34,0,1,  1,'h30,1,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h38,0,1,  1,'h30,2,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h3C,0,1,  1,'h30,3,1,1,1,1));
        vecs.push_back(mk(0,1,0,1,'h50,1,1,  1,'h30,4,0,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,1,     1,'h34,3,1,1,0,1));
        // flush at count 3 with a competing push
        vecs.push_back(mk(0,1,1,1,'h40,1,1,  0,'h34,3,1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,1,     0,0,0,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h44,0,1,  0,0,0,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,1,     1,'h44,1,1,0,0,1));
        // clock enable low: nothing moves
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0,1,'h48,1,1, 1,'h44,1,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,1,1,     1,'h44,1,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,1,     0,0,0,1,0,0,1));
        // reset mid-stream with clkEn low
        vecs.push_back(mk(0,1,0,1,'h60,0,1,  0,0,0,1,0,0,1));
        vecs.push_back(mk(0,1,0,1,'h64,0,1,  1,'h60,1,1,0,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,1,     1,'h60,2,1,0,0,1));
        vecs.push_back(mk(0,1,0,0,0,0,1,     0,0,0,1,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ce, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            #4;
            if (vecs[i].chk) begin
                e_ov = vecs[i].e_ov;
                e_pc = vecs[i].e_pc;
                e_in = (vecs[i].e_cnt != 3'd0) ? instr_of(vecs[i].e_pc) : 32'h0;
                if (BYP && vecs[i].e_cnt == 3'd0 && vecs[i].iv && !vecs[i].fl) begin
                    e_ov = 1'b1;
                    e_pc = vecs[i].pc;
                    e_in = instr_of(vecs[i].pc);
                end
                cmp("outValid",   i, 32'(fq.outValid),   32'(e_ov));
                cmp("outPC",      i, fq.outPC,           e_pc);
                cmp("outInstr",   i, fq.outInstr,        e_in);
                cmp("count",      i, 32'(fq.count),      32'(vecs[i].e_cnt));
                cmp("inReady",    i, 32'(fq.inReady),    32'(vecs[i].e_ird));
                cmp("stallReq",   i, 32'(fq.stallReq),   32'(vecs[i].e_st));
                cmp("stallStart", i, 32'(fq.stallStart), 32'(vecs[i].e_ss));
                cmp("overflow",   i, 32'(fq.overflow),   32'(vecs[i].e_ovf));
            end
            @(posedge clk);
            #1;
        end

        // Empty queue, instruction arrives with decode ready
        drive(0, 1, 0, 1, 32'h100, 1);
        #4;
        cmp("byp_outValid", 100, 32'(fq.outValid), BYP ? 32'd1 : 32'd0);
        cmp("byp_outPC",    100, fq.outPC,          BYP ? 32'h100 : 32'h0);
        cmp("byp_count",    100, 32'(fq.count),     32'd0);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 0, 32'h0, 0);
        #4;
        cmp("byp_outValid", 101, 32'(fq.outValid), BYP ? 32'd0 : 32'd1);
        cmp("byp_outPC",    101, fq.outPC,          BYP ? 32'h0 : 32'h100);
        cmp("byp_count",    101, 32'(fq.count),     BYP ? 32'd0 : 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 0, 32'h0, 1);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 0, 32'h0, 0);
        #4;
        cmp("drain_count", 102, 32'(fq.count), 32'd0);
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
